// File: rtl/score_arbiter.sv
// -----------------------------------------------------------------------------
// score_arbiter
//
// Round-robin scheduler sharing the single BCD score incrementer between
// several independent scoring sources. Each source pulses a request per point
// it awards; points accumulate in per-source saturating counters and are
// drained one point per cycle by the current owner, in bursts of at most
// MAX_BURST points, before ownership rotates.
//
// Handshake: a source requests a point by holding req[i] high for exactly one
// cycle; there is no back-pressure, a request is always accepted into pend[i]
// (or flagged in overflow[i] when pend[i] is already saturated). Downstream,
// each cycle with inc=1 transfers exactly one point to the score module on the
// same clock edge that pend[owner] is decremented.
//
// Parameters
//   N_REQ     : number of requesters
//   CNT_W     : width of each pending-point counter (saturates at 2^CNT_W-1)
//   MAX_BURST : maximum consecutive points granted to one owner (>= 1)
//
// Ports
//   clk           : system clock
//   reset         : synchronous active-high reset, clears all state
//   req           : per-source one-cycle point requests
//   game_active   : high = incrementer may be driven, low = pause
//   score_full    : score module saturated, no increments allowed
//   clear_pending : synchronous flush of all pending points
//   inc           : increment enable to the score module
//   grant         : one-hot owner of the incrementer, zero when idle
//   pending_any   : some pending counter is nonzero
//   overflow      : sticky per-source overflow flags
//   fsm_state     : debug view of the arbiter state (0 = IDLE, 1 = SERVE)
// -----------------------------------------------------------------------------
module score_arbiter #(
    parameter int N_REQ     = 4,
    parameter int CNT_W     = 3,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             game_active,
    input  logic             score_full,
    input  logic             clear_pending,
    output logic             inc,
    output logic [N_REQ-1:0] grant,
    output logic             pending_any,
    output logic [N_REQ-1:0] overflow,
    output logic             fsm_state
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BC_W  = $clog2(MAX_BURST + 1);

    localparam logic [CNT_W-1:0] PEND_MAX  = '1;
    localparam logic [BC_W-1:0]  BURST_END = BC_W'(MAX_BURST);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(N_REQ - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0] pend     [N_REQ];
    logic [CNT_W-1:0] pend_nxt [N_REQ];
    logic [N_REQ-1:0] overflow_nxt;
    logic [N_REQ-1:0] dec;
    logic [N_REQ-1:0] nonzero;

    logic [PTR_W-1:0] ptr, ptr_nxt;
    logic [PTR_W-1:0] owner, owner_nxt;
    logic [BC_W-1:0]  bcnt, bcnt_nxt;

    logic             found;
    logic [PTR_W-1:0] pick;

    // Index (base + off) modulo N_REQ; works for non-power-of-two N_REQ.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                  input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N_REQ) begin
            sum = sum - N_REQ;
        end
        return PTR_W'(sum);
    endfunction

    // ------------------------------------------------------------------
    // Output decode: registered state qualified by the live pause inputs,
    // so inc drops in the same cycle game_active falls.
    // ------------------------------------------------------------------
    assign inc       = (state == SERVE) && game_active && !score_full;
    assign fsm_state = state;

    always_comb begin
        grant = '0;
        for (int i = 0; i < N_REQ; i++) begin
            grant[i] = (state == SERVE) && (owner == PTR_W'(i));
        end
    end

    always_comb begin
        nonzero = '0;
        for (int i = 0; i < N_REQ; i++) begin
            nonzero[i] = (pend[i] != '0);
        end
    end

    assign pending_any = |nonzero;

    // ------------------------------------------------------------------
    // Pending counters. A request on a saturated counter flags overflow and
    // adds nothing; if that counter is also being decremented the request
    // and the decrement cancel, leaving it at the maximum.
    // ------------------------------------------------------------------
    always_comb begin
        dec          = '0;
        overflow_nxt = overflow;
        for (int i = 0; i < N_REQ; i++) begin
            pend_nxt[i] = pend[i];
            dec[i]      = inc && (owner == PTR_W'(i));
            if (clear_pending) begin
                // Same-cycle requests are discarded with the flush.
                pend_nxt[i] = '0;
            end else begin
                if (req[i] && (pend[i] == PEND_MAX)) begin
                    overflow_nxt[i] = 1'b1;
                end
                if (req[i] && !dec[i] && (pend[i] != PEND_MAX)) begin
                    pend_nxt[i] = pend[i] + CNT_W'(1);
                end else if (!req[i] && dec[i]) begin
                    pend_nxt[i] = pend[i] - CNT_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Round-robin search: first nonzero counter at or after ptr.
    // ------------------------------------------------------------------
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        for (int off = 0; off < N_REQ; off++) begin
            if (!found && nonzero[wrap_add(ptr, off)]) begin
                found = 1'b1;
                pick  = wrap_add(ptr, off);
            end
        end
    end

    // ------------------------------------------------------------------
    // Arbiter FSM next state.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        bcnt_nxt  = bcnt;
        ptr_nxt   = ptr;

        case (state)
            IDLE: begin
                if (found && !score_full) begin
                    state_nxt = SERVE;
                    owner_nxt = pick;
                    bcnt_nxt  = '0;
                end
            end
            SERVE: begin
                // While paused nothing moves: owner, bcnt and pend are held.
                if (inc) begin
                    bcnt_nxt = bcnt + BC_W'(1);
                    if ((pend_nxt[owner] == '0) || (bcnt_nxt == BURST_END)) begin
                        state_nxt = IDLE;
                        ptr_nxt   = (owner == LAST_IDX) ? '0 : owner + PTR_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Flush wins over any exit or selection; the rotation pointer keeps
        // its value so fairness history survives the flush.
        if (clear_pending) begin
            state_nxt = IDLE;
            bcnt_nxt  = '0;
            ptr_nxt   = ptr;
        end
    end

    // ------------------------------------------------------------------
    // State registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= '0;
            bcnt     <= '0;
            ptr      <= '0;
            overflow <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                pend[i] <= '0;
            end
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            bcnt     <= bcnt_nxt;
            ptr      <= ptr_nxt;
            overflow <= overflow_nxt;
            for (int i = 0; i < N_REQ; i++) begin
                pend[i] <= pend_nxt[i];
            end
        end
    end

endmodule
